// File: rtl/uart_start_detector.sv
// UART receive front end: synchronises the serial line and qualifies start bits
// on oversampled strobes, with glitch rejection, clear/re-arm guard and break detection.
module uart_start_detector #(
    parameter int MinLowSamples  = 4,
    parameter int MinIdleSamples = 2,
    parameter int BreakSamples   = 80
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_trigger,
    input  logic raw_data,
    input  logic clear,
    output logic start_bit_detected,
    output logic start_pulse,
    output logic break_detected
);

    localparam int CW = $clog2(BreakSamples + 1);
    localparam logic [CW-1:0] LOW_TH  = CW'(MinLowSamples);
    localparam logic [CW-1:0] IDLE_TH = CW'(MinIdleSamples);
    localparam logic [CW-1:0] BRK_TH  = CW'(BreakSamples);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        QUALIFY   = 2'd1,
        DETECTED  = 2'd2,
        WAIT_IDLE = 2'd3
    } state_t;

    // Count up by one, holding at BreakSamples so the counter never wraps.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v >= BRK_TH) ? BRK_TH : v + ONE;
    endfunction

    logic line_p0, line_p1;
    logic line;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d, count_inc;
    logic          counting_q, counting_d;
    logic          sbd_d, pulse_d, brk_d;

    // Input synchroniser: two flops, reset to the idle (high) line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_p0 <= 1'b1;
            line_p1 <= 1'b1;
        end else begin
            line_p0 <= raw_data;
            line_p1 <= line_p0;
        end
    end

    assign line      = line_p1;
    assign count_inc = sat_inc(count_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q            <= IDLE;
            count_q            <= '0;
            counting_q         <= 1'b0;
            start_bit_detected <= 1'b0;
            start_pulse        <= 1'b0;
            break_detected     <= 1'b0;
        end else begin
            state_q            <= state_d;
            count_q            <= count_d;
            counting_q         <= counting_d;
            start_bit_detected <= sbd_d;
            start_pulse        <= pulse_d;
            break_detected     <= brk_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        counting_d = counting_q;
        sbd_d      = start_bit_detected;
        pulse_d    = 1'b0;
        brk_d      = break_detected;

        if (clear) begin
            state_d    = WAIT_IDLE;
            count_d    = '0;
            counting_d = 1'b0;
            sbd_d      = 1'b0;
            brk_d      = 1'b0;
        end else if (sample_trigger) begin
            case (state_q)
                IDLE: begin
                    if (!line) begin
                        count_d = ONE;
                        if (LOW_TH <= ONE) begin
                            state_d    = DETECTED;
                            sbd_d      = 1'b1;
                            pulse_d    = 1'b1;
                            counting_d = 1'b1;
                        end else begin
                            state_d = QUALIFY;
                        end
                    end
                end
                QUALIFY: begin
                    if (line) begin
                        state_d = IDLE;
                        count_d = '0;
                    end else begin
                        count_d = count_inc;
                        if (count_inc >= LOW_TH) begin
                            state_d    = DETECTED;
                            sbd_d      = 1'b1;
                            pulse_d    = 1'b1;
                            counting_d = 1'b1;
                        end
                    end
                end
                DETECTED: begin
                    // The break run must be unbroken from the first low sample;
                    // one high sample freezes the count until the next clear.
                    if (line) begin
                        counting_d = 1'b0;
                    end else if (counting_q) begin
                        count_d = count_inc;
                        if (count_inc == BRK_TH) begin
                            brk_d = 1'b1;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (!line) begin
                        count_d = '0;
                    end else if (count_inc >= IDLE_TH) begin
                        state_d = IDLE;
                        count_d = '0;
                    end else begin
                        count_d = count_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_start_detector.md
Name: uart_start_detector

Overview:
- Parametrised UART receive front end that qualifies start bits on a sample_trigger-strobed, oversampled serial line.
- Adds to the basic detector:
  - a 2-flop input synchroniser
  - a programmable qualification threshold
  - a one-cycle start pulse
  - re-arm via clear, with an idle-line guard
  - line-break detection
- Sits between the pad and the UART bit sampler. sample_trigger comes from a pulse_generator at Oversample × baud.

Parameters:
- MinLowSamples, 4: consecutive low samples needed to qualify a start bit; range 1..BreakSamples-1.
- MinIdleSamples, 2: consecutive high samples needed before re-arming after clear; range ≥1.
- BreakSamples, 80: consecutive low samples, counted from the first low, that declare a break; default is 10 bits × 8 oversample.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- sample_trigger  in  1  one-clk sample strobe; the line is only evaluated when this is high.
- raw_data  in  1  asynchronous serial line; idles high.
- clear  in  1  one-clk re-arm request.
- start_bit_detected  out  1  sticky; set on qualification, cleared by clear or rst.
- start_pulse  out  1  one-clk pulse on qualification.
- break_detected  out  1  sticky; set when the line is low for ≥BreakSamples samples.

Behaviour:
- Reset (rst low, asynchronous):
  - synchroniser flops = 1
  - state = IDLE, count = 0
  - all outputs = 0
- Synchroniser: line = raw_data delayed by 2 clk. Only line is used internally.
- count: width $clog2(BreakSamples+1); saturates at BreakSamples and never wraps.
- A "sample" is any clk edge with sample_trigger = 1. Edges without sample_trigger change nothing except clear handling.
- IDLE:
  - sample with line = 0 → QUALIFY, count = 1.
  - If MinLowSamples = 1, go straight to DETECTED and apply the qualification actions below.
- QUALIFY:
  - sample line = 0 → count++.
  - When count reaches MinLowSamples → DETECTED. On the same edge:
    - start_bit_detected ← 1
    - start_pulse ← 1 for exactly one clk
  - sample line = 1 before the threshold → IDLE, count = 0, no outputs change. This is glitch rejection: MinLowSamples-1 low samples are rejected.
- DETECTED:
  - Outputs are registered: start_bit_detected goes high on the edge that registers the qualifying sample.
  - The line returning high does not clear start_bit_detected.
  - While line = 0, count keeps incrementing.
  - When count reaches BreakSamples, set break_detected (sticky).
  - Any high sample stops counting; count is held.
- clear = 1 (any state, any cycle) → on that edge:
  - start_bit_detected ← 0, break_detected ← 0, start_pulse ← 0
  - count ← 0
  - state ← WAIT_IDLE
- clear has priority over a coincident sample; that sample is discarded.
- WAIT_IDLE:
  - sample line = 1 → count++.
  - sample line = 0 → count = 0.
  - count reaches MinIdleSamples → IDLE, count = 0.
  - This prevents re-triggering on the remainder of a start bit or a break.
- Latency:
  - raw_data falling edge to the first counted sample: 2 clk plus the wait for the next trigger.
  - Qualifying sample to start_bit_detected/start_pulse: 1 clk (registered).
- Reset asserted mid-QUALIFY or mid-DETECTED: outputs drop immediately, without waiting for a clock edge. On release the block is in IDLE.
- start_pulse never asserts twice without an intervening clear.

Test Plan:
- rst held low 400 clk; raw_data toggled → all outputs stay 0.
- Defaults, Period=10: raw_data low for 4 samples then high → start_bit_detected = 1 and start_pulse high for exactly 1 clk, 1 clk after the 4th low sample. start_bit_detected stays 1 for 500 clk.
- raw_data low for 3 samples then high → all outputs 0 for 500 clk. Then raw_data low for 8 samples → detection occurs at the 4th low sample, not the 8th.
- raw_data low for 80 samples → start_bit_detected set after 4 samples, break_detected set after the 80th sample. Both stay set until clear.
- After detection, pulse clear while raw_data is still low, then release high → no new detection until 2 high samples. A following 4-sample low gives a second start_pulse.
- clear on the same clk as a qualifying sample_trigger → clear wins: start_bit_detected = 0, state WAIT_IDLE. Also: assert rst mid-QUALIFY → outputs 0 asynchronously, before the next clk edge.
